// File: rtl/fifo_cell_pkg.sv
// Shared definitions for the cell reassembly path.
//   - CELL_MAX / MIN_CELL : cell payload limits used by the cutter and merger
//   - LEN_W               : width of the per-cell length field
//   - ENT_*               : bit offsets inside a buffered entry
//                           {data, [err], fir, lst}
//   - clamp_len()         : maps an illegal cell length onto the maximum
// Optional build macro: MERGE_ERR_EN adds the per-packet error bit (ENT_ERR)
// to every entry, moving the data field up by one bit.
package fifo_cell_pkg;

    localparam int unsigned CELL_MAX = 1500;
    localparam int unsigned MIN_CELL = 46;
    localparam int unsigned LEN_W    = 11;

    localparam int unsigned ENT_LST  = 0;
    localparam int unsigned ENT_FIR  = 1;
    localparam int unsigned ENT_ERR  = 2;
`ifdef MERGE_ERR_EN
    localparam int unsigned ENT_DATA = 3;
`else
    localparam int unsigned ENT_DATA = 2;
`endif

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return ((len == '0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/fifo_merge_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data      : push; ignored while full
//   rd_en, rd_data      : pop; rd_data always shows the head entry
//   empty, full         : occupancy flags
//   upd_en, upd_mask    : OR upd_mask into the most recently written entry
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] upd_mask
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    last_ptr;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        rd_data  = mem[rd_ptr_q];
        last_ptr = (wr_ptr_q == '0) ? AW'(DEPTH - 1) : wr_ptr_q - AW'(1);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (upd_en) begin
            mem[last_ptr] <= mem[last_ptr] | upd_mask;
        end
    end

endmodule

// File: rtl/fifo_merge.sv
// fifo_merge: rebuilds packets from a cell stream (store-and-forward).
//   din/din_vld/din_sop/din_eop : incoming cell bytes, eop includes padding
//   din_len/din_last            : valid bytes in this cell / cell ends packet,
//                                 both sampled with din_sop
//   dout/dout_vld/dout_sop/dout_eop : registered, gap-free packet bursts
//   dout_err (MERGE_ERR_EN only): with dout_eop, packet saw a short cell,
//                                 implicit close, clamped length or drop
// Optional build macro: MERGE_ERR_EN.
module fifo_merge #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4096,
    parameter int unsigned CELL_MAX   = fifo_cell_pkg::CELL_MAX
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               din,
    input  logic                            din_vld,
    input  logic                            din_sop,
    input  logic                            din_eop,
    input  logic [fifo_cell_pkg::LEN_W-1:0] din_len,
    input  logic                            din_last,
    output logic [DATA_W-1:0]               dout,
    output logic                            dout_vld,
    output logic                            dout_sop,
    output logic                            dout_eop
`ifdef MERGE_ERR_EN
    ,
    output logic                            dout_err
`endif
);

    import fifo_cell_pkg::*;

    localparam int unsigned ENT_W = DATA_W + ENT_DATA;
    localparam int unsigned PC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = PC_W + 2;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CELL_MAX);
    localparam logic [PC_W-1:0]  PC_MAX  = '1;

    logic [LEN_W-1:0]  len_q, len_d, cnt_wr_q, cnt_wr_d;
    logic              last_q, last_d, cell_open_q, cell_open_d;
    logic              in_pkt_q, in_pkt_d, rd_flag_q, rd_flag_d;
    logic [PC_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [SUM_W-1:0]  pkt_sum;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d, dout_sop_q, dout_sop_d;
    logic              dout_eop_q, dout_eop_d;

    logic              sop, active, store, cell_end, lst_bit, fir_bit;
    logic              close_lst, in_pkt_now, eff_last, pkt_dec, q_lst;
    logic [LEN_W-1:0]  eff_len, cnt;
    logic              wr_en, rd_en, fifo_empty, fifo_full, upd_en;
    logic [ENT_W-1:0]  wr_data, rd_data, upd_mask;

    // ---------------- write side ----------------
    always_comb begin
        sop        = din_vld && din_sop;
        active     = din_vld && (din_sop || cell_open_q);
        eff_len    = sop ? clamp_len(din_len, LEN_MAX) : len_q;
        eff_last   = sop ? din_last : last_q;
        cnt        = sop ? '0 : cnt_wr_q;
        // A new sop while the last cell of a packet is still open and its
        // lst was never written: the packet is closed by tagging the entry
        // already in the buffer rather than the byte arriving now.
        close_lst  = sop && cell_open_q && last_q && in_pkt_q;
        in_pkt_now = in_pkt_q && !close_lst;
        store      = active && (cnt < eff_len);
        cell_end   = (cnt == eff_len - LEN_W'(1)) || din_eop;
        lst_bit    = store && eff_last && cell_end;
        fir_bit    = !in_pkt_now;
        wr_en      = store && !fifo_full;
        upd_en     = close_lst && !fifo_empty;

        len_d  = len_q;
        last_d = last_q;
        if (sop) begin
            len_d  = eff_len;
            last_d = din_last;
        end

        cnt_wr_d    = cnt_wr_q;
        cell_open_d = cell_open_q;
        if (active) begin
            if (din_eop) begin
                cnt_wr_d    = '0;
                cell_open_d = 1'b0;
            end else begin
                cnt_wr_d    = (cnt == '1) ? cnt : cnt + LEN_W'(1);
                cell_open_d = 1'b1;
            end
        end

        if (lst_bit) begin
            in_pkt_d = 1'b0;
        end else if (store) begin
            in_pkt_d = 1'b1;
        end else begin
            in_pkt_d = in_pkt_now;
        end

        // Up to two packets can complete in one cycle (implicit close plus a
        // one-byte last cell), so the counter update is done in a wider sum.
        pkt_sum = SUM_W'(pkt_cnt_q) + SUM_W'(lst_bit) + SUM_W'(close_lst);
        if (pkt_dec && (pkt_sum != '0)) begin
            pkt_sum = pkt_sum - SUM_W'(1);
        end
        pkt_cnt_d = (pkt_sum > SUM_W'(PC_MAX)) ? PC_MAX : pkt_sum[PC_W-1:0];
    end

`ifdef MERGE_ERR_EN
    logic err_q, err_d, err_ev, err_pkt;

    always_comb begin
        err_ev  = (sop && (eff_len != din_len))
               || (store && din_eop && (cnt != eff_len - LEN_W'(1)))
               || (store && fifo_full)
               || (sop && cell_open_q && in_pkt_q && !close_lst);
        err_pkt = (err_q && !close_lst) || err_ev;
        err_d   = lst_bit ? 1'b0 : err_pkt;
        wr_data = {din, err_pkt, fir_bit, lst_bit};
        upd_mask          = '0;
        upd_mask[ENT_LST] = 1'b1;
        upd_mask[ENT_ERR] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    always_comb begin
        wr_data           = {din, fir_bit, lst_bit};
        upd_mask          = '0;
        upd_mask[ENT_LST] = 1'b1;
    end
`endif

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .upd_en   (upd_en),
        .upd_mask (upd_mask)
    );

    // ---------------- read side ----------------
    always_comb begin
        rd_en   = rd_flag_q && !fifo_empty;
        q_lst   = rd_data[ENT_LST];
        pkt_dec = rd_en && q_lst;

        rd_flag_d = rd_flag_q;
        if (!rd_flag_q && (pkt_cnt_q != '0)) begin
            rd_flag_d = 1'b1;
        end else if (pkt_dec) begin
            rd_flag_d = 1'b0;
        end

        dout_d     = '0;
        dout_vld_d = 1'b0;
        dout_sop_d = 1'b0;
        dout_eop_d = 1'b0;
        if (rd_en) begin
            dout_d     = rd_data[ENT_DATA +: DATA_W];
            dout_vld_d = 1'b1;
            dout_sop_d = rd_data[ENT_FIR];
            dout_eop_d = q_lst;
        end
    end

`ifdef MERGE_ERR_EN
    logic dout_err_q, dout_err_d;

    always_comb begin
        dout_err_d = rd_en && q_lst && rd_data[ENT_ERR];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_err_q <= 1'b0;
        end else begin
            dout_err_q <= dout_err_d;
        end
    end

    assign dout_err = dout_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            last_q      <= 1'b0;
            cnt_wr_q    <= '0;
            cell_open_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            rd_flag_q   <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_sop_q  <= 1'b0;
            dout_eop_q  <= 1'b0;
        end else begin
            len_q       <= len_d;
            last_q      <= last_d;
            cnt_wr_q    <= cnt_wr_d;
            cell_open_q <= cell_open_d;
            in_pkt_q    <= in_pkt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            rd_flag_q   <= rd_flag_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_sop_q  <= dout_sop_d;
            dout_eop_q  <= dout_eop_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;

endmodule
